// File: rtl/sec_word_encoder.sv
// sec_word_encoder
//
// Packs a byte stream into 32-bit data words and generates the 8 check bits
// that make the downstream single-error-correcting syndrome stage see an
// all-zero syndrome. Each finished word, its check bits and the captured
// check-enable are held in a one-entry output register with valid/ready.
// A single data bit can optionally be flipped after check generation so the
// downstream correction path can be exercised.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   byte available
//   in_ready   out  byte accepted when in_valid && in_ready
//   in_byte    in   [0:7] data byte, index 0 first in word order
//   in_last    in   this byte completes the word, remaining bytes are zero
//   chk_en     in   sampled with the first byte of a word, drives R_o
//   inj_en     in   sampled with the completing byte, flips one data bit
//   inj_idx    in   [4:0] data bit to flip
//   out_valid  out  word held in the output register
//   out_ready  in   consumer takes the word when out_valid && out_ready
//   ID_o       out  [0:31] data word
//   IC_o       out  [0:7] check bits (always of the uninjected word)
//   R_o        out  check enable for the downstream syndrome stage
module sec_word_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:7]  in_byte,
    input  logic        in_last,
    input  logic        chk_en,
    input  logic        inj_en,
    input  logic [4:0]  inj_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] ID_o,
    output logic [0:7]  IC_o,
    output logic        R_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [0:31] pack_q, pack_d;
    logic        chk_q, chk_d;
    logic        out_valid_q, out_valid_d;
    logic [0:31] id_q, id_d;
    logic [0:7]  ic_q, ic_d;
    logic        r_q, r_d;

    logic        accept;
    logic        complete;
    logic        chk_eff;
    logic [0:31] word;

    // Check bits: nibble parities folded pairwise (G) combined with the
    // column parities of each 16-bit half (XE).
    function automatic logic [0:7] calc_check(input logic [0:31] w);
        logic [0:7] f;
        logic [0:7] g;
        logic [0:7] xe;
        logic [0:7] ic;
        for (int n = 0; n < 8; n++) begin
            f[n] = w[4*n] ^ w[4*n+1] ^ w[4*n+2] ^ w[4*n+3];
        end
        g = {f[0] ^ f[1], f[2] ^ f[3], f[0] ^ f[2], f[1] ^ f[3],
             f[4] ^ f[5], f[6] ^ f[7], f[4] ^ f[6], f[5] ^ f[7]};
        for (int j = 0; j < 4; j++) begin
            xe[j] = w[j] ^ w[j+4] ^ w[j+8] ^ w[j+12];
        end
        for (int j = 4; j < 8; j++) begin
            xe[j] = w[j+12] ^ w[j+16] ^ w[j+20] ^ w[j+24];
        end
        ic[0:3] = g[4:7] ^ xe[0:3];
        ic[4:7] = g[0:3] ^ xe[4:7];
        return ic;
    endfunction

    // A byte may enter whenever the output slot is free or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((cnt_q == 2'd3) || in_last);

    // The first byte of a word supplies chk_en directly; later bytes use
    // the captured copy.
    assign chk_eff  = (cnt_q == 2'd0) ? chk_en : chk_q;

    // The packing register is cleared after every completion, so bytes
    // above the current position are already zero when in_last cuts a word
    // short.
    always_comb begin
        word = pack_q;
        case (cnt_q)
            2'd0:    word[0:7]   = in_byte;
            2'd1:    word[8:15]  = in_byte;
            2'd2:    word[16:23] = in_byte;
            default: word[24:31] = in_byte;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        pack_d      = pack_q;
        chk_d       = chk_q;
        out_valid_d = out_valid_q;
        id_d        = id_q;
        ic_d        = ic_q;
        r_d         = r_q;

        if (accept) begin
            chk_d = chk_eff;
            if (complete) begin
                cnt_d  = 2'd0;
                pack_d = '0;
            end else begin
                cnt_d  = cnt_q + 2'd1;
                pack_d = word;
            end
        end

        // A completion always wins over a drain in the same cycle, which
        // keeps out_valid high across back-to-back words.
        if (complete) begin
            out_valid_d = 1'b1;
            id_d        = word;
            if (inj_en) begin
                id_d[inj_idx] = ~word[inj_idx];
            end
            ic_d = calc_check(word);
            r_d  = chk_eff;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= 2'd0;
            pack_q      <= '0;
            chk_q       <= 1'b0;
            out_valid_q <= 1'b0;
            id_q        <= '0;
            ic_q        <= '0;
            r_q         <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            chk_q       <= chk_d;
            out_valid_q <= out_valid_d;
            id_q        <= id_d;
            ic_q        <= ic_d;
            r_q         <= r_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ID_o      = id_q;
    assign IC_o      = ic_q;
    assign R_o       = r_q;

endmodule

// File: doc/sec_word_encoder.md
# sec_word_encoder

Upstream companion to the single-error-correcting syndrome/correction stage. It takes a byte stream over a valid/ready handshake and packs it into 32-bit data words. For each word it computes the 8 check bits that give an all-zero syndrome in the downstream stage, then presents data, check bits and the check-enable `R` through a one-entry registered output with valid/ready. An optional single-bit error injector exercises the downstream correction path.

## Interface
- No parameters; data width 32, check width 8 and byte width 8 are fixed.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_byte`  in  [0:7]  data byte; index 0 is first in word order.
- `in_last`  in  1  completes the word with this byte; unfilled bytes are zero.
- `chk_en`  in  1  sampled with the first byte of a word; becomes `R_o`.
- `inj_en`  in  1  sampled with the word-completing byte; flips one data bit after check generation.
- `inj_idx`  in  5  index of the data bit to flip, 0..31.
- `out_valid`  out  1  word held in the output register.
- `out_ready`  in  1  consumer takes the word when `out_valid && out_ready`.
- `ID_o`  out  [0:31]  data word.
- `IC_o`  out  [0:7]  check bits.
- `R_o`  out  1  check enable for the downstream syndrome stage.

## Operation
- Byte packing: the k-th accepted byte of a word (k = 0..3) sets `ID[8k+i] = in_byte[i]`.
- A 2-bit byte counter `cnt` holds the next k.
- A word completes on an accepted byte with `cnt==3` or with `in_last=1`. Bytes above k stay 0. `cnt` then returns to 0.
- Check generation is combinational over the completed word W, before injection:
  - Nibble parity: `F[n] = ^W[4n..4n+3]`, n = 0..7.
  - `G0=F0^F1`, `G1=F2^F3`, `G2=F0^F2`, `G3=F1^F3`, `G4=F4^F5`, `G5=F6^F7`, `G6=F4^F6`, `G7=F5^F7`.
  - For j = 0..3: `XE[j] = W[j]^W[j+4]^W[j+8]^W[j+12]`.
  - For j = 4..7: `XE[j] = W[j+12]^W[j+16]^W[j+20]^W[j+24]`.
  - `IC[0..3] = G4..G7 ^ XE[0..3]`.
  - `IC[4..7] = G0..G3 ^ XE[4..7]`.
- Injection: if `inj_en` is set, `ID_o = W ^ (1 << inj_idx)` in [0:31] index order. `IC_o` always reflects the uninjected W.
- `R_o` carries the `chk_en` value captured at `cnt==0` for that word.
- Handshake:
  - `in_ready = !out_valid || out_ready`. This is combinational and valid for every byte, not only the completing one.
  - Output register: set on word completion; cleared on `out_valid && out_ready` with no new completion in the same cycle.
  - Simultaneous drain and completion: the new word is loaded and `out_valid` stays 1.
- A partial word waits in the packing register indefinitely; no timeout.

## Timing
- Reset (clocked with `rst_n=0`) clears `cnt`, the packing register, captured `chk_en`, `out_valid`, `ID_o`, `IC_o` and `R_o` to 0.
- Reset mid-word discards the partial word.
- Reset with `out_valid=1` drops the pending word.
- Latency: completing byte accepted at edge t gives `out_valid=1` with `ID_o`/`IC_o`/`R_o` valid after edge t.
- Throughput: one byte per cycle, so one full word per 4 cycles with `out_ready` held high.
- Output data is stable while `out_valid && !out_ready`.
- `in_valid` without `in_ready` changes no state.
- `in_last` with `cnt==3` behaves the same as `cnt==3` alone.

## Test plan
- Reset, then bytes 00,00,00,00 with `chk_en=1` -> one cycle after the 4th byte, `out_valid=1`, `ID_o=0`, `IC_o=0`, `R_o=1`.
- Single-bit words:
  - `ID[0]=1`, all other bits 0 -> `IC_o` has bits 0, 4, 6 set, all others 0.
  - `ID[31]=1` -> bits 1, 3, 7 set.
  - All-ones word -> `IC_o=0`.
- Back-to-back words with `out_ready=1`: 8 consecutive bytes -> two outputs 4 cycles apart, `in_ready` constantly 1.
- Backpressure:
  - `out_ready=0` with a word pending -> `in_ready=0` and outputs stable for 10 cycles.
  - Raising `out_ready` while the completing byte is presented -> the new word loads in the same cycle and `out_valid` never drops.
- `in_last` on the 2nd byte (AB,CD) -> `ID_o[0:15]` = the two bytes, `ID_o[16:31]=0`; the next word starts at `cnt=0`.
- Injection: all-zero word, `inj_en=1`, `inj_idx=0` -> `ID_o[0]=1`, `IC_o=0`. Fed to the downstream decoder with `R=1`, its corrected output is all zero.
- Reset asserted after 2 bytes -> `out_valid` stays 0. A following clean 4-byte word is packed from `ID[0]`.
